// File: rtl/mp3_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mp3_ctrl_pkg
//  Description : Shared constants and command decoding for the MP3 front-panel
//                control stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mp3_ctrl_pkg;

    localparam int                   NUM_SONGS         = 5;
    localparam logic [NUM_SONGS-1:0] SONG_ONEHOT_RESET = 5'b00001;
    localparam logic [2:0]           SONG_IDX_LAST     = 3'(NUM_SONGS - 1);
    localparam logic [7:0]           VOL_MAX           = 8'hFE;
    localparam logic [7:0]           VOL_MIN           = 8'h00;

    // Net effect of a pair of opposing button pulses in one cycle
    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_INC  = 2'd1,
        CMD_DEC  = 2'd2
    } step_cmd_e;

    // Opposing pulses arriving together cancel out
    function automatic step_cmd_e decode_step(input logic inc, input logic dec);
        step_cmd_e cmd;
        cmd = CMD_HOLD;
        if (inc && !dec) cmd = CMD_INC;
        if (dec && !inc) cmd = CMD_DEC;
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mp3_ctrl_panel_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-flop synchroniser, debouncer, press-edge pulse generator and
//                optional hold-to-repeat for one raw push-button.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 15000000
) (
    input  logic I_CLK,
    input  logic RST,
    input  logic btn_raw,
    output logic press,
    output logic level
);
    import mp3_ctrl_pkg::*;

    localparam int             DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q,  press_d;
    logic            rpt_fire;

    // Debounce: count consecutive cycles the synced level disagrees with stable
    always_comb begin
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        press_d  = rpt_fire;
        if (sync_q[1] == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = sync_q[1];
            db_cnt_d = '0;
            // Only a 0->1 transition is a press; releases are silent
            press_d  = press_d | sync_q[1];
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Synchroniser, stable level, debounce counter and press pulse registers
    always_ff @(posedge I_CLK) begin
        if (!RST) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_raw};
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
        end
    end

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
            localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
            localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

            logic [RPT_W-1:0] rpt_cnt_q;
            logic             rpt_on_q;   // first repeat already fired, now on the period
            logic             rpt_hit;

            assign rpt_hit  = stable_q && (rpt_cnt_q == (rpt_on_q ? PER_LAST : DLY_LAST));
            assign rpt_fire = rpt_hit;

            // Hold counter: initial delay, then fixed period, cleared on release
            always_ff @(posedge I_CLK) begin
                if (!RST || !stable_q) begin
                    rpt_cnt_q <= '0;
                    rpt_on_q  <= 1'b0;
                end else if (rpt_hit) begin
                    rpt_cnt_q <= '0;
                    rpt_on_q  <= 1'b1;
                end else begin
                    rpt_cnt_q <= rpt_cnt_q + 1'b1;
                end
            end
        end else begin : g_no_repeat
            assign rpt_fire = 1'b0;
        end
    endgenerate

    assign press = press_q;
    assign level = stable_q;

endmodule
`default_nettype wire

// File: rtl/mp3_ctrl_panel.sv
`default_nettype none
// ============================================================================
//  Module      : mp3_ctrl_panel
//  Description : Front-panel control for the MP3 core: four debounced buttons
//                drive a one-hot song rotator and a saturating volume register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mp3_ctrl_panel #(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter int         REPEAT_DELAY    = 50000000,
    parameter int         REPEAT_PERIOD   = 15000000,
    parameter logic [7:0] VOL_STEP        = 8'h10,
    parameter logic [7:0] VOL_INIT        = 8'h40
) (
    input  logic       I_CLK,
    input  logic       RST,
    input  logic       BTN_NEXT,
    input  logic       BTN_PREV,
    input  logic       BTN_VOL_UP,
    input  logic       BTN_VOL_DN,
    output logic [4:0] music_select,
    output logic [7:0] vol,
    output logic [2:0] song_idx
);
    import mp3_ctrl_pkg::*;

    logic [3:0] btn_raw;
    logic [3:0] btn_press;
    logic [3:0] btn_level_unused;   // stable levels are not needed at this stage

    assign btn_raw = {BTN_VOL_DN, BTN_VOL_UP, BTN_PREV, BTN_NEXT};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_EN       (i >= 2),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_btn (
                .I_CLK   (I_CLK),
                .RST     (RST),
                .btn_raw (btn_raw[i]),
                .press   (btn_press[i]),
                .level   (btn_level_unused[i])
            );
        end
    endgenerate

    logic [NUM_SONGS-1:0] sel_q, sel_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           vol_q, vol_d;
    logic [8:0]           vol_sum;
    step_cmd_e            song_cmd, vol_cmd;

    assign song_cmd = decode_step(btn_press[0], btn_press[1]);
    assign vol_cmd  = decode_step(btn_press[2], btn_press[3]);
    assign vol_sum  = {1'b0, vol_q} + {1'b0, VOL_STEP};

    // Next song/volume: one-hot rotate with index kept in lockstep, saturating volume
    always_comb begin
        sel_d = sel_q;
        idx_d = idx_q;
        vol_d = vol_q;
        case (song_cmd)
            CMD_INC: begin
                sel_d = {sel_q[NUM_SONGS-2:0], sel_q[NUM_SONGS-1]};
                idx_d = (idx_q == SONG_IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            end
            CMD_DEC: begin
                sel_d = {sel_q[0], sel_q[NUM_SONGS-1:1]};
                idx_d = (idx_q == 3'd0) ? SONG_IDX_LAST : idx_q - 3'd1;
            end
            default: ;
        endcase
        // INC on volume means louder, i.e. less attenuation
        case (vol_cmd)
            CMD_INC: vol_d = (vol_q >= VOL_STEP) ? vol_q - VOL_STEP : VOL_MIN;
            CMD_DEC: vol_d = (vol_sum > {1'b0, VOL_MAX}) ? VOL_MAX : vol_sum[7:0];
            default: ;
        endcase
    end

    // Output registers; only legal values are ever loaded
    always_ff @(posedge I_CLK) begin
        if (!RST) begin
            sel_q <= SONG_ONEHOT_RESET;
            idx_q <= 3'd0;
            vol_q <= VOL_INIT;
        end else begin
            sel_q <= sel_d;
            idx_q <= idx_d;
            vol_q <= vol_d;
        end
    end

    assign music_select = sel_q;
    assign song_idx     = idx_q;
    assign vol          = vol_q;

endmodule
`default_nettype wire

// File: tb/tb_mp3_ctrl_panel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mp3_ctrl_panel
//  Description : Directed self-checking bench for mp3_ctrl_panel using small
//                debounce/repeat timings.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mp3_ctrl_panel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       b_next, b_prev, b_up, b_dn;
    logic [4:0] sel;
    logic [7:0] vol;
    logic [2:0] idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mp3_ctrl_panel #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .VOL_STEP        (8'h10),
        .VOL_INIT        (8'h40)
    ) dut (
        .I_CLK        (clk),
        .RST          (rst_n),
        .BTN_NEXT     (b_next),
        .BTN_PREV     (b_prev),
        .BTN_VOL_UP   (b_up),
        .BTN_VOL_DN   (b_dn),
        .music_select (sel),
        .vol          (vol),
        .song_idx     (idx)
    );

    typedef struct {
        string      name;
        bit         nx, pv, up, dn;
        logic [4:0] sel;
        logic [2:0] idx;
        logic [7:0] vol;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [4:0] es,
                               input logic [2:0] ei, input logic [7:0] ev);
        check({name, ".sel"}, 32'(sel), 32'(es));
        check({name, ".idx"}, 32'(idx), 32'(ei));
        check({name, ".vol"}, 32'(vol), 32'(ev));
    endtask

    // One active edge, then land on the following negedge for sampling/driving
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_btns(input bit nx, input bit pv, input bit up, input bit dn);
        b_next = nx; b_prev = pv; b_up = up; b_dn = dn;
    endtask

    task automatic do_reset();
        set_btns(0, 0, 0, 0);
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    // Volume after a button has been held k edges: first step at edge 7,
    // second at edge 27 (20 after the first), then every 8 edges.
    function automatic logic [7:0] vol_after(input logic [7:0] v0, input int k, input bit up);
        int n;
        int v;
        if (k < 7)       n = 0;
        else if (k < 27) n = 1;
        else             n = 2 + (k - 27) / 8;
        v = int'(v0);
        for (int j = 0; j < n; j++) begin
            if (up) v = (v >= 16) ? v - 16 : 0;
            else    v = (v + 16 > 254) ? 254 : v + 16;
        end
        return 8'(v);
    endfunction

    logic [4:0] ps;
    logic [2:0] pi;
    logic [7:0] pvv;

    initial begin
        tbl[0]  = '{"next1",    1, 0, 0, 0, 5'b00100, 3'd2, 8'h40};
        tbl[1]  = '{"next2",    1, 0, 0, 0, 5'b01000, 3'd3, 8'h40};
        tbl[2]  = '{"next3",    1, 0, 0, 0, 5'b10000, 3'd4, 8'h40};
        tbl[3]  = '{"next_wrap",1, 0, 0, 0, 5'b00001, 3'd0, 8'h40};
        tbl[4]  = '{"prev_wrap",0, 1, 0, 0, 5'b10000, 3'd4, 8'h40};
        tbl[5]  = '{"prev",     0, 1, 0, 0, 5'b01000, 3'd3, 8'h40};
        tbl[6]  = '{"next_prev",1, 1, 0, 0, 5'b01000, 3'd3, 8'h40};
        tbl[7]  = '{"vol_up",   0, 0, 1, 0, 5'b01000, 3'd3, 8'h30};
        tbl[8]  = '{"vol_dn",   0, 0, 0, 1, 5'b01000, 3'd3, 8'h40};
        tbl[9]  = '{"up_dn",    0, 0, 1, 1, 5'b01000, 3'd3, 8'h40};
        tbl[10] = '{"up_next",  1, 0, 1, 0, 5'b10000, 3'd4, 8'h30};
        tbl[11] = '{"dn_prev",  0, 1, 0, 1, 5'b01000, 3'd3, 8'h40};

        set_btns(0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state and idle stability
        check_state("reset", 5'b00001, 3'd0, 8'h40);
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (k % 10 == 9) check_state("idle", 5'b00001, 3'd0, 8'h40);
        end

        // First press latency: change lands on exactly the 7th edge
        set_btns(1, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 6) check_state("lat_before", 5'b00001, 3'd0, 8'h40);
            if (k == 7) check_state("lat_at", 5'b00010, 3'd1, 8'h40);
        end
        set_btns(0, 0, 0, 0);
        for (int k = 0; k < 12; k++) cyc();
        check_state("lat_release", 5'b00010, 3'd1, 8'h40);

        // Table: press for 10 cycles, check edges 6/7, release and recheck
        ps = 5'b00010; pi = 3'd1; pvv = 8'h40;
        for (int i = 0; i < 12; i++) begin
            set_btns(tbl[i].nx, tbl[i].pv, tbl[i].up, tbl[i].dn);
            for (int k = 1; k <= 10; k++) begin
                cyc();
                if (k == 6) check_state({tbl[i].name, "_e6"}, ps, pi, pvv);
                if (k == 7) check_state({tbl[i].name, "_e7"}, tbl[i].sel, tbl[i].idx, tbl[i].vol);
            end
            set_btns(0, 0, 0, 0);
            for (int k = 0; k < 12; k++) cyc();
            check_state({tbl[i].name, "_rel"}, tbl[i].sel, tbl[i].idx, tbl[i].vol);
            ps = tbl[i].sel; pi = tbl[i].idx; pvv = tbl[i].vol;
        end

        // Short bounce alone gives nothing
        for (int k = 0; k < 4; k++) begin
            b_next = (k % 2 == 0);
            cyc();
        end
        b_next = 1'b0;
        for (int k = 0; k < 12; k++) cyc();
        check_state("bounce_only", 5'b01000, 3'd3, 8'h40);

        // Bounce followed by a real hold gives exactly one step
        for (int k = 0; k < 4; k++) begin
            b_next = (k % 2 == 0);
            cyc();
        end
        b_next = 1'b1;
        for (int k = 0; k < 10; k++) cyc();
        b_next = 1'b0;
        for (int k = 0; k < 12; k++) cyc();
        check_state("bounce_hold", 5'b10000, 3'd4, 8'h40);

        // Volume up auto-repeat down to the loudest setting
        do_reset();
        b_up = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            check("vol_up_hold", 32'(vol), 32'(vol_after(8'h40, k, 1'b1)));
        end
        b_up = 1'b0;
        for (int k = 0; k < 12; k++) cyc();
        check("vol_up_rel", 32'(vol), 32'h00);

        // Volume down auto-repeat, through 8'hF0 into saturation at 8'hFE
        b_dn = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            cyc();
            check("vol_dn_hold", 32'(vol), 32'(vol_after(8'h00, k, 1'b0)));
        end
        b_dn = 1'b0;
        for (int k = 0; k < 12; k++) cyc();
        check_state("vol_dn_rel", 5'b00001, 3'd0, 8'hFE);

        // Reset pulse while volume up is held
        b_up = 1'b1;
        for (int k = 0; k < 30; k++) cyc();
        rst_n = 1'b0;
        cyc();
        check_state("midhold_reset", 5'b00001, 3'd0, 8'h40);
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            check("midhold_resume", 32'(vol), 32'(vol_after(8'h40, k, 1'b1)));
        end
        b_up = 1'b0;
        for (int k = 0; k < 12; k++) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
